// File: rtl/keypad_scanner_if.sv
// Signal bundle between the 4x4 keypad scanner and the keypad/display side.
// The scanner uses the master modport; the keypad/consumer uses the slave modport.
interface keypad_scanner_if;
    logic [3:0]  row;
    logic [3:0]  col;
    logic [3:0]  keyVal;
    logic        keyValid;
    logic        keyHeld;
    logic [15:0] entryVal;

    modport master (
        input  row,
        output col,
        output keyVal,
        output keyValid,
        output keyHeld,
        output entryVal
    );

    modport slave (
        output row,
        input  col,
        input  keyVal,
        input  keyValid,
        input  keyHeld,
        input  entryVal
    );
endinterface

// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner with press/release debounce and a four-key entry history.
//   state    | meaning
//   SCAN     | rotate the active-low column drive, look for a single pressed row
//   DEBOUNCE | column frozen, count stable cycles of the latched row pattern
//   HELD     | key accepted, wait for all rows to go high
//   RELEASE  | count stable all-high cycles before resuming the scan
module keypad_scanner #(
    parameter int SCAN_TICKS   = 1000,
    parameter int DEBOUNCE_CNT = 50000
) (
    input  logic             clk,
    input  logic             reset,
    keypad_scanner_if.master kp
);
    localparam int TW = $clog2(SCAN_TICKS);
    localparam int DW = $clog2(DEBOUNCE_CNT);
    localparam logic [TW-1:0] TICK_LAST = TW'(SCAN_TICKS - 1);
    localparam logic [DW-1:0] DEB_LAST  = DW'(DEBOUNCE_CNT - 1);

    typedef enum logic [1:0] {SCAN, DEBOUNCE, HELD, RELEASE} state_t;

    state_t         state_q, state_d;
    logic [3:0]     sync1_q, sync1_d;
    logic [3:0]     rs_q, rs_d;
    logic [1:0]     col_idx_q, col_idx_d;
    logic [TW-1:0]  tick_q, tick_d;
    logic [DW-1:0]  deb_q, deb_d;
    logic [3:0]     pat_q, pat_d;
    logic [3:0]     key_val_q, key_val_d;
    logic           key_valid_q, key_valid_d;
    logic           key_held_q, key_held_d;
    logic [15:0]    entry_val_q, entry_val_d;
    logic [DW-1:0]  deb_inc;
    logic [3:0]     code;

    function automatic logic single_low(input logic [3:0] v);
        logic [3:0] x;
        x = ~v;
        return (x != 4'd0) && ((x & (x - 4'd1)) == 4'd0);
    endfunction

    function automatic logic [3:0] key_code(input logic [3:0] pat, input logic [1:0] c);
        logic [1:0] r;
        logic [3:0] k;
        case (pat)
            4'b1110: r = 2'd0;
            4'b1101: r = 2'd1;
            4'b1011: r = 2'd2;
            default: r = 2'd3;
        endcase
        case ({r, c})
            4'd0:  k = 4'h1;  4'd1:  k = 4'h2;  4'd2:  k = 4'h3;  4'd3:  k = 4'hA;
            4'd4:  k = 4'h4;  4'd5:  k = 4'h5;  4'd6:  k = 4'h6;  4'd7:  k = 4'hB;
            4'd8:  k = 4'h7;  4'd9:  k = 4'h8;  4'd10: k = 4'h9;  4'd11: k = 4'hC;
            4'd12: k = 4'h0;  4'd13: k = 4'hF;  4'd14: k = 4'hE;  default: k = 4'hD;
        endcase
        return k;
    endfunction

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= SCAN;
            sync1_q     <= 4'b1111;
            rs_q        <= 4'b1111;
            col_idx_q   <= 2'd0;
            tick_q      <= '0;
            deb_q       <= '0;
            pat_q       <= 4'b1111;
            key_val_q   <= 4'h0;
            key_valid_q <= 1'b0;
            key_held_q  <= 1'b0;
            entry_val_q <= 16'h0000;
        end else begin
            state_q     <= state_d;
            sync1_q     <= sync1_d;
            rs_q        <= rs_d;
            col_idx_q   <= col_idx_d;
            tick_q      <= tick_d;
            deb_q       <= deb_d;
            pat_q       <= pat_d;
            key_val_q   <= key_val_d;
            key_valid_q <= key_valid_d;
            key_held_q  <= key_held_d;
            entry_val_q <= entry_val_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        sync1_d     = kp.row;
        rs_d        = sync1_q;
        col_idx_d   = col_idx_q;
        tick_d      = tick_q;
        deb_d       = deb_q;
        pat_d       = pat_q;
        key_val_d   = key_val_q;
        key_valid_d = 1'b0;
        key_held_d  = key_held_q;
        entry_val_d = entry_val_q;
        deb_inc     = (deb_q == DEB_LAST) ? deb_q : deb_q + 1'b1;
        code        = key_code(pat_q, col_idx_q);

        case (state_q)
            SCAN: begin
                if (tick_q == TICK_LAST) begin
                    if (single_low(rs_q)) begin
                        pat_d   = rs_q;
                        deb_d   = '0;
                        state_d = DEBOUNCE;
                    end else begin
                        tick_d    = '0;
                        col_idx_d = col_idx_q + 2'd1;
                    end
                end else begin
                    tick_d = tick_q + 1'b1;
                end
            end
            DEBOUNCE: begin
                if (rs_q == pat_q) begin
                    if (deb_q == DEB_LAST) begin
                        key_val_d   = code;
                        key_valid_d = 1'b1;
                        entry_val_d = {entry_val_q[11:0], code};
                        key_held_d  = 1'b1;
                        state_d     = HELD;
                    end else begin
                        deb_d = deb_inc;
                    end
                end else begin
                    // a bounce abandons this column and moves on rather than re-latching it
                    state_d   = SCAN;
                    col_idx_d = col_idx_q + 2'd1;
                    tick_d    = '0;
                end
            end
            HELD: begin
                if (rs_q == 4'b1111) begin
                    deb_d   = '0;
                    state_d = RELEASE;
                end
            end
            RELEASE: begin
                if (rs_q == 4'b1111) begin
                    if (deb_q == DEB_LAST) begin
                        key_held_d = 1'b0;
                        state_d    = SCAN;
                        col_idx_d  = 2'd0;
                        tick_d     = '0;
                    end else begin
                        deb_d = deb_inc;
                    end
                end else begin
                    state_d = HELD;
                end
            end
            default: state_d = SCAN;
        endcase
    end

    assign kp.col      = ~(4'b0001 << col_idx_q);
    assign kp.keyVal   = key_val_q;
    assign kp.keyValid = key_valid_q;
    assign kp.keyHeld  = key_held_q;
    assign kp.entryVal = entry_val_q;
endmodule

// File: tb/tb_keypad_scanner.sv
// Randomized scoreboard bench for keypad_scanner: a physical keypad model drives the rows,
// expected keys are queued at press time and checked by an independent monitor.
module tb_keypad_scanner;
    localparam int ST = 4;
    localparam int DC = 8;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    keypad_scanner_if kp();

    keypad_scanner #(.SCAN_TICKS(ST), .DEBOUNCE_CNT(DC)) dut (
        .clk   (clk),
        .reset (reset),
        .kp    (kp)
    );

    // bit r*4+c set means the switch at row r, column c is closed
    logic [15:0] pressed;
    always_comb begin
        kp.row = 4'hF;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (pressed[r*4+c] && !kp.col[c]) kp.row[r] = 1'b0;
    end

    typedef struct {
        logic [3:0]  key;
        logic [15:0] entry;
    } exp_t;

    exp_t        exp_q[$];
    logic [15:0] model_entry;
    logic [3:0]  shown_key;
    logic [15:0] shown_entry;
    int          checks = 0;
    int          errors = 0;

    logic [3:0] keymap [0:15] = '{4'h1, 4'h2, 4'h3, 4'hA,
                                  4'h4, 4'h5, 4'h6, 4'hB,
                                  4'h7, 4'h8, 4'h9, 4'hC,
                                  4'h0, 4'hF, 4'hE, 4'hD};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // monitor: pops an expectation on every keyValid, otherwise holds outputs to the last accepted key
    initial begin
        exp_t e;
        shown_key   = 4'h0;
        shown_entry = 16'h0;
        forever begin
            @(negedge clk);
            if (reset) begin
                shown_key   = 4'h0;
                shown_entry = 16'h0;
            end else if (kp.keyValid) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_keyValid: keyVal %0h with no press pending at %0t", kp.keyVal, $time);
                end else begin
                    e = exp_q.pop_front();
                    check("keyVal", kp.keyVal, e.key);
                    check("entryVal", kp.entryVal, e.entry);
                    check("keyHeld_on_valid", kp.keyHeld, 1);
                    shown_key   = e.key;
                    shown_entry = e.entry;
                end
            end else begin
                check("keyVal_stable", kp.keyVal, shown_key);
                check("entryVal_stable", kp.entryVal, shown_entry);
            end
        end
    end

    task automatic wait_held(input logic lvl, input int budget, input string name, output int n);
        n = 0;
        while (kp.keyHeld !== lvl && n < budget) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (kp.keyHeld !== lvl) begin
            errors++;
            $display("FAIL %s: keyHeld still %b after %0d cycles, wanted %b", name, kp.keyHeld, n, lvl);
        end
    endtask

    task automatic wait_col(input logic [3:0] v, input int budget, input string name);
        int n;
        n = 0;
        while (kp.col !== v && n < budget) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (kp.col !== v) begin
            errors++;
            $display("FAIL %s: col %b never reached %b", name, kp.col, v);
        end
    endtask

    task automatic expect_key(input int r, input int c);
        exp_t e;
        model_entry = {model_entry[11:0], keymap[r*4+c]};
        e.key   = keymap[r*4+c];
        e.entry = model_entry;
        exp_q.push_back(e);
    endtask

    task automatic press_key(input int r, input int c, input int hold);
        int n;
        expect_key(r, c);
        pressed[r*4+c] = 1'b1;
        wait_held(1'b1, 200, "press_accept", n);
        repeat (hold) @(negedge clk);
        pressed[r*4+c] = 1'b0;
        wait_held(1'b0, 200, "release_done", n);
    endtask

    task automatic reset_and_check();
        @(negedge clk);
        reset = 1'b1;
        #1;
        check("rst_col", kp.col, 4'b1110);
        check("rst_keyVal", kp.keyVal, 4'h0);
        check("rst_keyValid", kp.keyValid, 0);
        check("rst_keyHeld", kp.keyHeld, 0);
        check("rst_entryVal", kp.entryVal, 16'h0000);
        exp_q.delete();
        model_entry = 16'h0;
    endtask

    task automatic check_rotation(input string name);
        logic [3:0] ex;
        for (int k = 0; k <= 16; k++) begin
            ex = ~(4'b0001 << ((k / ST) % 4));
            check(name, kp.col, ex);
            @(negedge clk);
        end
    endtask

    initial begin
        int n;
        int cnt;
        pressed     = 16'h0;
        model_entry = 16'h0;
        reset       = 1'b1;
        reset_and_check();
        repeat (2) @(negedge clk);
        reset = 1'b0;
        check_rotation("col_rotate_after_reset");

        // key sequence 1, A, 0, D, E from a clean history
        press_key(0, 0, 5);
        press_key(0, 3, 5);
        press_key(3, 0, 5);
        press_key(3, 3, 5);
        press_key(3, 2, 5);
        check("entry_seq_final", kp.entryVal, 16'hA0DE);

        // row 1 / column 2 gives key 6
        reset_and_check();
        repeat (2) @(negedge clk);
        reset = 1'b0;
        press_key(1, 2, 3);
        check("key6_value", kp.keyVal, 4'h6);
        check("key6_entry", kp.entryVal, 16'h0006);

        // short glitch on column 1 must be rejected and scanning moves to column 2
        wait_col(4'b1110, 40, "glitch_align0");
        wait_col(4'b1101, 40, "glitch_align1");
        cnt = 1;
        pressed[1] = 1'b1;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            if (i == 3) pressed[1] = 1'b0;
            if (kp.col !== 4'b1101) break;
            cnt++;
        end
        pressed[1] = 1'b0;
        check("glitch_froze_col", cnt > ST, 1);
        check("glitch_next_col", kp.col, 4'b1011);
        check("glitch_no_hold", kp.keyHeld, 0);
        repeat (30) @(negedge clk);

        // bounce on release: one pulse only, release needs a full quiet window
        expect_key(2, 1);
        pressed[9] = 1'b1;
        wait_held(1'b1, 200, "bounce_press", n);
        repeat (4) @(negedge clk);
        pressed[9] = 1'b0;
        repeat (3) @(negedge clk);
        pressed[9] = 1'b1;
        repeat (2) @(negedge clk);
        pressed[9] = 1'b0;
        check("bounce_still_held", kp.keyHeld, 1);
        wait_held(1'b0, 200, "bounce_release", n);
        check("bounce_release_len", (n >= DC) && (n <= DC + 6), 1);

        // two rows low together is not a key; the scan keeps rotating
        pressed = 16'h0F0F;
        wait_col(4'b0111, 40, "multi_align0");
        wait_col(4'b1110, 40, "multi_align1");
        check_rotation("col_rotate_multi");
        check("multi_no_hold", kp.keyHeld, 0);
        pressed = 16'h0;
        repeat (10) @(negedge clk);

        // reset while holding F aborts cleanly; releasing afterwards is silent
        press_key(0, 0, 0);
        expect_key(3, 1);
        pressed[13] = 1'b1;
        wait_held(1'b1, 200, "held_F", n);
        repeat (3) @(negedge clk);
        reset_and_check();
        pressed[13] = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (60) @(negedge clk);
        check("post_reset_held", kp.keyHeld, 0);
        check("post_reset_entry", kp.entryVal, 16'h0000);

        // random keys with random hold and gap times
        for (int i = 0; i < 12; i++) begin
            press_key($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 12));
            repeat ($urandom_range(0, 10)) @(negedge clk);
        end

        repeat (20) @(negedge clk);
        check("scoreboard_drained", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/keypad_scanner.md
KEYPAD_SCANNER -- requirements
Module: keypad_scanner

Interface
REQ-001 The block SHALL have the parameter SCAN_TICKS, default 1000, giving the number of clk cycles each column is driven while scanning (minimum 4).
REQ-002 The block SHALL have the parameter DEBOUNCE_CNT, default 50000, giving the number of consecutive stable clk cycles needed to accept a press or a release (minimum 2).
REQ-003 clk  input  1  single system clock; all state changes on its rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 row  input  4  keypad row sense lines, active-low (pulled up externally); row[0] is the top row.
REQ-006 col  output  4  keypad column drives, active-low one-hot; col[0] is the leftmost column.
REQ-007 keyVal  output  4  hex code of the last accepted key.
REQ-008 keyValid  output  1  one-cycle pulse marking acceptance of a new key.
REQ-009 keyHeld  output  1  high while an accepted key has not yet been released (debounced).
REQ-010 entryVal  output  16  last four accepted keys, most recent in [3:0], oldest in [15:12]; feeds four display digits.

Function
REQ-011 row SHALL pass through a 2-flop synchronizer, and all decisions SHALL use the synchronized value rs.
REQ-012 The FSM SHALL have exactly four states: SCAN, DEBOUNCE, HELD, RELEASE.
REQ-013 In SCAN, the block SHALL drive column c (0..3) low for SCAN_TICKS cycles, then advance to c+1, wrapping from 3 to 0.
REQ-014 In SCAN, on the last tick of a column period, exactly one low bit in rs SHALL latch (c, rs), clear the debounce counter, freeze col, and go to DEBOUNCE.
REQ-015 In SCAN, an all-high rs, or more than one low bit in rs, SHALL be treated as no key and scanning SHALL continue.
REQ-016 In DEBOUNCE, each cycle with rs equal to the latched pattern SHALL increment the counter; any mismatch SHALL return to SCAN with the next column and a restarted tick count.
REQ-017 When the counter reaches DEBOUNCE_CNT-1 with rs still matching, the block SHALL, on the next edge, load keyVal, pulse keyValid for exactly one cycle, set entryVal to {entryVal[11:0], keyVal}, set keyHeld, and go to HELD.
REQ-018 Key map by row/col (r0..r3 each listing col0,col1,col2,col3) SHALL be: r0 = 1,2,3,A; r1 = 4,5,6,B; r2 = 7,8,9,C; r3 = 0,F,E,D.
REQ-019 In HELD, col SHALL stay frozen; an all-high rs SHALL clear the counter and go to RELEASE.
REQ-020 In RELEASE, each all-high cycle SHALL increment the counter; any low rs bit SHALL return to HELD with no new keyValid.
REQ-021 When the RELEASE counter reaches DEBOUNCE_CNT-1, the block SHALL clear keyHeld and return to SCAN at column 0.
REQ-022 keyVal and entryVal SHALL change only on a keyValid cycle.
REQ-023 A single physical press SHALL produce exactly one keyValid, with no auto-repeat.
REQ-024 The tick and debounce counters SHALL be sized with $clog2 of their parameter, SHALL saturate at their terminal count, and SHALL never wrap.

Reset
REQ-025 While reset is high, outputs SHALL be: col = 4'b1110, keyVal = 0, keyValid = 0, keyHeld = 0, entryVal = 16'h0000.
REQ-026 While reset is high, state SHALL be SCAN with column 0, both counters zero, and synchronizer flops set to 4'b1111.
REQ-027 Reset asserted in any state, including mid-debounce or while held, SHALL abort immediately with no keyValid pulse.
REQ-028 Scanning SHALL resume on the first clk edge after reset deasserts.

Verification (SCAN_TICKS=4, DEBOUNCE_CNT=8)
REQ-029 Press r1 (row=4'b1101) only while col[2] is low, held stable -> exactly one keyValid, keyVal=4'h6, entryVal=16'h0006, keyHeld=1.
REQ-030 Enter keys 1, A, 0, D, then E -> entryVal steps 0001, 001A, 01A0, 1A0D, A0DE; five keyValid pulses in total.
REQ-031 Glitch row low for 3 cycles during DEBOUNCE -> no keyValid; scanning resumes at the next column.
REQ-032 Bounce on release (high 3 cycles, low 2, then high) -> no second keyValid; keyHeld falls only after 8 consecutive high cycles.
REQ-033 Rows r0 and r2 low together -> no keyValid; col keeps rotating 1110, 1101, 1011, 0111, 1110.
REQ-034 Assert reset while in HELD after a key F -> outputs return to REQ-025 values; releasing the key afterwards produces no pulse.
